// File: rtl/clause_dispatch_unit.sv
// -----------------------------------------------------------------------------
// clause_dispatch_unit
//   Buffers clauses in a DEPTH-entry circular FIFO and hands them out to
//   NUM_ENGINE BCP engines. Each cycle in RUN, up to MAX_GRANTS head clauses
//   go to distinct engines that are not asserting back-pressure. Engines are
//   scanned round-robin starting at rr_ptr. Pushes while full are dropped and
//   latch a sticky overflow flag.
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   synchronous active-high reset (priority over flush)
//   flush_in      in   synchronous clear of FIFO, FSM and output registers
//   load_sig_in   in   push clause_in this cycle
//   clause_in     in   clause to push (CLA_W bits)
//   start_in      in   level dispatch enable
//   full_in       in   per-engine back-pressure, 1 = do not grant
//   clause_out    out  per-engine clause, valid when matching grant bit set
//   grant_out     out  registered one-cycle grant per engine
//   empty_out     out  occupancy is zero
//   full_out      out  occupancy is DEPTH
//   count_out     out  occupancy
//   overflow_out  out  sticky: push attempted while full
// -----------------------------------------------------------------------------
module clause_dispatch_unit #(
  parameter int NUM_ENGINE  = 4,
  parameter int LIT_IDX_MAX = 1024,
  parameter int CLA_LENGTH  = 3,
  parameter int DEPTH       = 32,
  parameter int MAX_GRANTS  = 4,
  localparam int VAR_LEN    = $clog2(LIT_IDX_MAX) + 1,
  localparam int CLA_W      = CLA_LENGTH * VAR_LEN,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush_in,
  input  logic                             load_sig_in,
  input  logic [CLA_W-1:0]                 clause_in,
  input  logic                             start_in,
  input  logic [NUM_ENGINE-1:0]            full_in,
  output logic [NUM_ENGINE-1:0][CLA_W-1:0] clause_out,
  output logic [NUM_ENGINE-1:0]            grant_out,
  output logic                             empty_out,
  output logic                             full_out,
  output logic [CNT_W-1:0]                 count_out,
  output logic                             overflow_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENG_W = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e state_q, state_d;
  logic   run_en;

  logic [CLA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]                 count_q, count_d;
  logic [PTR_W-1:0]                 head_q, head_d;
  logic [PTR_W-1:0]                 tail_q, tail_d;
  logic [ENG_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [NUM_ENGINE-1:0]            grant_q, grant_d;
  logic [NUM_ENGINE-1:0][CLA_W-1:0] clause_q, clause_d;
  logic                             overflow_q, overflow_d;

  logic             clear;
  logic             push_acc;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] n_gnt;
  logic [ENG_W-1:0] scan_eng;
  logic [ENG_W-1:0] last_eng;
  logic [PTR_W-1:0] rd_ptr;

  assign clear = reset | flush_in;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state, re-evaluated from start_in on every edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_in)  state_d = S_RUN;
      S_RUN:   if (!start_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run_en = (state_q == S_RUN);
  end

  // ---------------------------------------------------------------------------
  // Push side. full_out reflects the current occupancy, so a push at DEPTH is
  // dropped even if the same cycle pops entries.
  // ---------------------------------------------------------------------------
  assign push_acc = load_sig_in & ~full_out;

  always_ff @(posedge clock) begin
    if (push_acc && !clear) begin
      mem[tail_q] <= clause_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Dispatch: walk engines from rr_ptr, giving consecutive head entries to the
  // first eligible ones until min(count, MAX_GRANTS) grants have been issued.
  // Only entries below the current count are read, so the slot being written
  // this cycle is never forwarded.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_d  = '0;
    clause_d = clause_q;
    n_gnt    = '0;
    scan_eng = rr_ptr_q;
    last_eng = rr_ptr_q;
    rd_ptr   = head_q;
    limit    = (count_q > CNT_W'(MAX_GRANTS)) ? CNT_W'(MAX_GRANTS) : count_q;
    if (run_en) begin
      for (int j = 0; j < NUM_ENGINE; j++) begin
        scan_eng = ENG_W'((int'(rr_ptr_q) + j) % NUM_ENGINE);
        if (!full_in[scan_eng] && (n_gnt < limit)) begin
          rd_ptr             = head_q + PTR_W'(n_gnt);
          grant_d[scan_eng]  = 1'b1;
          clause_d[scan_eng] = mem[rd_ptr];
          last_eng           = scan_eng;
          n_gnt              = n_gnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    count_d    = count_q + CNT_W'(push_acc) - n_gnt;
    head_d     = head_q + PTR_W'(n_gnt);
    tail_d     = tail_q + PTR_W'(push_acc);
    overflow_d = overflow_q | (load_sig_in & full_out);
    rr_ptr_d   = rr_ptr_q;
    if (n_gnt != '0) begin
      rr_ptr_d = ENG_W'((int'(last_eng) + 1) % NUM_ENGINE);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear) begin
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      clause_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      clause_q   <= clause_d;
      overflow_q <= overflow_d;
    end
  end

  assign clause_out   = clause_q;
  assign grant_out    = grant_q;
  assign count_out    = count_q;
  assign empty_out    = (count_q == '0);
  assign full_out     = (count_q == CNT_W'(DEPTH));
  assign overflow_out = overflow_q;

endmodule

// File: tb/tb_clause_dispatch_unit.sv
// -----------------------------------------------------------------------------
// tb_clause_dispatch_unit
//   Directed scenarios plus randomized traffic, compared every cycle against a
//   queue-based reference model of the dispatcher.
// -----------------------------------------------------------------------------
module tb_clause_dispatch_unit;

  localparam int NE    = 4;
  localparam int DEPTH = 32;
  localparam int MAXG  = 4;
  localparam int CLA_W = 33;
  localparam int CNT_W = 6;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     flush_in;
  logic                     load_sig_in;
  logic [CLA_W-1:0]         clause_in;
  logic                     start_in;
  logic [NE-1:0]            full_in;
  logic [NE-1:0][CLA_W-1:0] clause_out;
  logic [NE-1:0]            grant_out;
  logic                     empty_out;
  logic                     full_out;
  logic [CNT_W-1:0]         count_out;
  logic                     overflow_out;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [CLA_W-1:0] mq[$];
  bit               m_run;
  int               m_rr;
  bit               m_ovf;
  logic [NE-1:0]    m_grant;
  logic [CLA_W-1:0] m_clause[NE];

  clause_dispatch_unit #(
    .NUM_ENGINE (NE),
    .LIT_IDX_MAX(1024),
    .CLA_LENGTH (3),
    .DEPTH      (DEPTH),
    .MAX_GRANTS (MAXG)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flush_in    (flush_in),
    .load_sig_in (load_sig_in),
    .clause_in   (clause_in),
    .start_in    (start_in),
    .full_in     (full_in),
    .clause_out  (clause_out),
    .grant_out   (grant_out),
    .empty_out   (empty_out),
    .full_out    (full_out),
    .count_out   (count_out),
    .overflow_out(overflow_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int  lim;
    int  n;
    int  e;
    int  last;
    bit  was_full;
    if (reset || flush_in) begin
      mq.delete();
      m_run   = 1'b0;
      m_rr    = 0;
      m_ovf   = 1'b0;
      m_grant = '0;
      for (int i = 0; i < NE; i++) m_clause[i] = '0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    m_grant  = '0;
    if (m_run) begin
      lim  = (mq.size() < MAXG) ? mq.size() : MAXG;
      n    = 0;
      last = -1;
      for (int k = 0; k < NE; k++) begin
        e = (m_rr + k) % NE;
        if (!full_in[e] && n < lim) begin
          m_grant[e]  = 1'b1;
          m_clause[e] = mq.pop_front();
          last        = e;
          n++;
        end
      end
      if (n > 0) m_rr = (last + 1) % NE;
    end
    if (load_sig_in) begin
      if (was_full) m_ovf = 1'b1;
      else          mq.push_back(clause_in);
    end
    m_run = start_in;
  endtask

  task automatic compare_all();
    check("grant", 64'(grant_out), 64'(m_grant));
    for (int i = 0; i < NE; i++)
      check($sformatf("clause%0d", i), 64'(clause_out[i]), 64'(m_clause[i]));
    check("count", 64'(count_out), 64'(mq.size()));
    check("empty", 64'(empty_out), 64'(mq.size() == 0));
    check("full", 64'(full_out), 64'(mq.size() == DEPTH));
    check("overflow", 64'(overflow_out), 64'(m_ovf));
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic push(input logic [CLA_W-1:0] v);
    load_sig_in = 1'b1;
    clause_in   = v;
    step();
    load_sig_in = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    flush_in    = 1'b0;
    load_sig_in = 1'b0;
    clause_in   = '0;
    start_in    = 1'b0;
    full_in     = '0;
    step();
    step();
    check("rst_empty", 64'(empty_out), 64'd1);
    check("rst_count", 64'(count_out), 64'd0);
    reset = 1'b0;

    // 24 clauses, all engines free: four per cycle in rotation order
    for (int i = 0; i < 24; i++) push(CLA_W'(i));
    start_in = 1'b1;
    step();
    check("t1_nogrant_yet", 64'(grant_out), 64'h0);
    step();
    check("t1_grant", 64'(grant_out), 64'hf);
    check("t1_c0", 64'(clause_out[0]), 64'd0);
    check("t1_c3", 64'(clause_out[3]), 64'd3);
    step();
    check("t1_c0b", 64'(clause_out[0]), 64'd4);
    for (int i = 0; i < 4; i++) step();
    check("t1_empty", 64'(empty_out), 64'd1);
    step();
    check("t1_idle_grant", 64'(grant_out), 64'h0);
    start_in = 1'b0;
    step();

    // engines 0 and 2 blocked
    for (int i = 0; i < 8; i++) push(CLA_W'(i));
    full_in  = 4'b0101;
    start_in = 1'b1;
    step();
    step();
    check("t2_grant", 64'(grant_out), 64'ha);
    check("t2_c1", 64'(clause_out[1]), 64'd0);
    check("t2_c3", 64'(clause_out[3]), 64'd1);
    check("t2_count", 64'(count_out), 64'd6);
    for (int i = 0; i < 4; i++) step();
    start_in = 1'b0;
    full_in  = '0;
    step();

    // fill to DEPTH then overflow with one more push
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) push(CLA_W'(100 + i));
    check("t4_full", 64'(full_out), 64'd1);
    check("t4_count", 64'(count_out), 64'd32);
    check("t4_noovf", 64'(overflow_out), 64'd0);
    push(CLA_W'(999));
    check("t4_ovf", 64'(overflow_out), 64'd1);
    start_in = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("t4_ovf_sticky", 64'(overflow_out), 64'd1);

    // single entry, only engine 0 free, push in the same cycle as the grant
    full_in = 4'b1110;
    for (int i = 0; i < 8; i++) step();
    check("t5_empty", 64'(empty_out), 64'd1);
    push(CLA_W'(7));
    load_sig_in = 1'b1;
    clause_in   = CLA_W'(99);
    step();
    load_sig_in = 1'b0;
    check("t5_count", 64'(count_out), 64'd1);
    step();
    check("t5_c0", 64'(clause_out[0]), 64'd99);

    // flush mid-run with 10 entries left
    full_in = 4'b1111;
    for (int i = 0; i < 12; i++) push(CLA_W'(200 + i));
    full_in = 4'b1110;
    step();
    step();
    check("t6_count10", 64'(count_out), 64'd10);
    full_in  = '0;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    check("t6_flush_count", 64'(count_out), 64'd0);
    check("t6_flush_grant", 64'(grant_out), 64'h0);
    step();
    check("t6_idle_after_flush", 64'(grant_out), 64'h0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      load_sig_in = ($urandom_range(0, 99) < 60);
      clause_in   = {$urandom, $urandom};
      if ($urandom_range(0, 99) < 5) start_in = ~start_in;
      full_in     = ($urandom_range(0, 1) == 0) ? NE'(0) : NE'($urandom);
      flush_in    = ($urandom_range(0, 999) < 8);
      reset       = ($urandom_range(0, 999) < 4);
      step();
    end
    reset       = 1'b0;
    flush_in    = 1'b0;
    load_sig_in = 1'b0;

    // final reset while active
    start_in = 1'b1;
    for (int i = 0; i < 6; i++) push(CLA_W'(i + 300));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("final_rst_empty", 64'(empty_out), 64'd1);
    check("final_rst_ovf", 64'(overflow_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
